// File: rtl/fifo_wr_ptr_gray_gen.sv
// fifo_wr_ptr_gray_gen: write-side binary/Gray pointer pair with full, almost-full, overflow and fill level
module fifo_wr_ptr_gray_gen #(
    parameter int ADDRWIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_we,
    input  logic [ADDRWIDTH:0]   i_rd_ptr_gray_sync,
    output logic [ADDRWIDTH-1:0] o_waddr,
    output logic                 o_wr_en_ram,
    output logic [ADDRWIDTH:0]   o_wr_ptr_bin,
    output logic [ADDRWIDTH:0]   o_wr_ptr_gray,
    output logic                 o_full,
    output logic                 o_afull,
    output logic                 o_overflow,
    output logic                 o_wr_ack,
    output logic [ADDRWIDTH:0]   o_wr_count
);
    localparam int PW = ADDRWIDTH + 1;
    localparam logic [ADDRWIDTH:0] AFT = PW'(AFULL_THRESH);
    logic [ADDRWIDTH:0] r_wr_ptr_bin, r_wr_ptr_gray, r_wr_count;
    logic               r_full, r_afull, r_overflow, r_wr_ack;
    logic               w_accept;
    logic [ADDRWIDTH:0] w_bin_next, w_gray_next, w_rd_bin, w_count_next, w_full_cmp;
    assign w_accept     = i_we & ~r_full;
    assign w_bin_next   = r_wr_ptr_bin + PW'(w_accept);
    assign w_gray_next  = w_bin_next ^ (w_bin_next >> 1);
    assign w_count_next = w_bin_next - w_rd_bin;
    assign w_full_cmp   = {~i_rd_ptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1], i_rd_ptr_gray_sync[ADDRWIDTH-2:0]};
    // Each binary bit of the read pointer is the XOR of all Gray bits at or above it.
    for (genvar k = 0; k <= ADDRWIDTH; k++) begin : g_rd_bin
        assign w_rd_bin[k] = ^(i_rd_ptr_gray_sync >> k);
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr_bin  <= '0;
            r_wr_ptr_gray <= '0;
            r_wr_count    <= '0;
            r_full        <= 1'b0;
            r_afull       <= 1'b0;
            r_overflow    <= 1'b0;
            r_wr_ack      <= 1'b0;
        end else begin
            r_wr_ptr_bin  <= w_bin_next;
            r_wr_ptr_gray <= w_gray_next;
            r_wr_count    <= w_count_next;
            r_full        <= (w_gray_next == w_full_cmp);
            r_afull       <= (w_count_next >= AFT);
            r_overflow    <= i_we & r_full;
            r_wr_ack      <= w_accept;
        end
    end
    assign o_waddr       = r_wr_ptr_bin[ADDRWIDTH-1:0];
    assign o_wr_en_ram   = w_accept;
    assign o_wr_ptr_bin  = r_wr_ptr_bin;
    assign o_wr_ptr_gray = r_wr_ptr_gray;
    assign o_full        = r_full;
    assign o_afull       = r_afull;
    assign o_overflow    = r_overflow;
    assign o_wr_ack      = r_wr_ack;
    assign o_wr_count    = r_wr_count;
endmodule

// File: tb/tb_fifo_wr_ptr_gray_gen.sv
// tb_fifo_wr_ptr_gray_gen: directed bench for the write pointer generator (ADDRWIDTH=3, AFULL_THRESH=6)
module tb_fifo_wr_ptr_gray_gen;
    logic       clk = 1'b0;
    logic       reset, we;
    logic [3:0] rd_g;
    logic [2:0] waddr;
    logic       wr_en_ram, full, afull, overflow, wr_ack;
    logic [3:0] bin, gray, cnt;
    int checks = 0;
    int errors = 0;

    fifo_wr_ptr_gray_gen #(.ADDRWIDTH(3), .AFULL_THRESH(6)) dut (
        .i_clk(clk), .i_reset(reset), .i_we(we), .i_rd_ptr_gray_sync(rd_g),
        .o_waddr(waddr), .o_wr_en_ram(wr_en_ram), .o_wr_ptr_bin(bin), .o_wr_ptr_gray(gray),
        .o_full(full), .o_afull(afull), .o_overflow(overflow), .o_wr_ack(wr_ack), .o_wr_count(cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] g(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " bin"}, 32'(bin), 0);
        chk({tag, " gray"}, 32'(gray), 0);
        chk({tag, " full"}, 32'(full), 0);
        chk({tag, " afull"}, 32'(afull), 0);
        chk({tag, " overflow"}, 32'(overflow), 0);
        chk({tag, " wr_ack"}, 32'(wr_ack), 0);
        chk({tag, " count"}, 32'(cnt), 0);
    endtask

    initial begin
        logic [3:0] cur, prev_g;
        reset = 1'b1; we = 1'b0; rd_g = 4'd0;
        tick();
        reset = 1'b0;
        chk_zero("reset");
        chk("reset waddr", 32'(waddr), 0);
        // fill with 8 writes, read pointer parked at 0
        for (int i = 0; i < 8; i++) begin
            we = 1'b1;
            #1;
            chk("fill waddr", 32'(waddr), i);
            chk("fill strobe", 32'(wr_en_ram), 1);
            tick();
            chk("fill ack", 32'(wr_ack), 1);
            chk("fill bin", 32'(bin), i + 1);
            chk("fill count", 32'(cnt), i + 1);
            chk("fill afull", 32'(afull), (i + 1 >= 6) ? 1 : 0);
            chk("fill full", 32'(full), (i == 7) ? 1 : 0);
        end
        chk("full gray", 32'(gray), 32'hC);
        // writes against a full FIFO are rejected
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ovf strobe", 32'(wr_en_ram), 0);
            tick();
            chk("ovf pulse", 32'(overflow), 1);
            chk("ovf ack", 32'(wr_ack), 0);
            chk("ovf bin", 32'(bin), 8);
        end
        // one read frees a slot
        we = 1'b0; rd_g = 4'b0001;
        tick();
        chk("rd1 full", 32'(full), 0);
        chk("rd1 count", 32'(cnt), 7);
        chk("rd1 afull", 32'(afull), 1);
        chk("rd1 overflow", 32'(overflow), 0);
        we = 1'b1;
        #1;
        chk("rd1 waddr", 32'(waddr), 0);
        chk("rd1 strobe", 32'(wr_en_ram), 1);
        tick();
        chk("rd1 bin", 32'(bin), 9);
        chk("rd1 gray", 32'(gray), 32'hD);
        chk("refull", 32'(full), 1);
        // almost-full threshold crossing via read pointer
        we = 1'b0; rd_g = g(4'd3);
        tick();
        chk("af6 count", 32'(cnt), 6);
        chk("af6 afull", 32'(afull), 1);
        rd_g = g(4'd4);
        tick();
        chk("af5 count", 32'(cnt), 5);
        chk("af5 afull", 32'(afull), 0);
        // wrap-around with read pointer trailing by one
        cur = 4'd9;
        for (int i = 0; i < 16; i++) begin
            prev_g = gray;
            rd_g = g(cur);
            we = 1'b1;
            tick();
            cur = cur + 4'd1;
            chk("wrap bin", 32'(bin), 32'(cur));
            chk("wrap gray", 32'(gray), 32'(g(cur)));
            chk("wrap onebit", $countones(prev_g ^ gray), 1);
            chk("wrap full", 32'(full), 0);
            chk("wrap count", 32'(cnt), 1);
        end
        we = 1'b0; prev_g = gray;
        tick();
        chk("idle gray", 32'(gray), 32'(prev_g));
        chk("idle ack", 32'(wr_ack), 0);
        // refill to full then reset with a write pending
        we = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("pre-reset bin", 32'(bin), 0);
        chk("pre-reset full", 32'(full), 1);
        chk("pre-reset count", 32'(cnt), 8);
        reset = 1'b1; rd_g = 4'd0;
        tick();
        chk_zero("midreset");
        reset = 1'b0;
        #1;
        chk("post waddr", 32'(waddr), 0);
        chk("post strobe", 32'(wr_en_ram), 1);
        tick();
        chk("post ack", 32'(wr_ack), 1);
        chk("post bin", 32'(bin), 1);
        chk("post gray", 32'(gray), 1);
        we = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
